// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared types and constants for the ground-collision scheduler:
//   - tile_entry_t  : one ground-tile table entry {valid, x[9:0], y[8:0]}
//   - scan_state_e  : scheduler FSM states (IDLE, SCAN, DRAIN, DONE)
//   - FLAG_*        : bit positions inside the 4-bit {left,right,up,down} flags
//   - PARK_X/PARK_Y : off-screen coordinates driven when no tile is presented
//   - sprite sizes  : character 47x41, ground tile 25x24
//   - make_tile()   : builds the tile layout (rows of 25 tiles along the ground)
// Optional feature macro used by the scheduler: SCAN_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
package collision_pkg;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [8:0] y;
  } tile_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  localparam int FLAG_DOWN  = 0;
  localparam int FLAG_UP    = 1;
  localparam int FLAG_RIGHT = 2;
  localparam int FLAG_LEFT  = 3;

  localparam logic [9:0] PARK_X = 10'h3FF;
  localparam logic [8:0] PARK_Y = 9'h1FF;

  localparam int BLUE_W = 47;
  localparam int BLUE_H = 41;
  localparam int TILE_W = 25;
  localparam int TILE_H = 24;

  // Ground layout: 25 tiles per row, first row at y=456, further rows stack upward.
  localparam int TILES_PER_ROW = 25;
  localparam int GROUND_Y0     = 456;

  function automatic tile_entry_t make_tile(input int idx, input logic valid);
    tile_entry_t e;
    e.valid = valid;
    e.x     = 10'((idx % TILES_PER_ROW) * TILE_W);
    e.y     = 9'(GROUND_Y0 - (idx / TILES_PER_ROW) * TILE_H);
    return e;
  endfunction

endpackage

// File: rtl/collision_scheduler_if.sv
// -----------------------------------------------------------------------------
// collision_scheduler_if
// Bundle of the scheduler's frame/character/checker signals.
//   frame_start   : vsync pulse that starts a scan          (master -> slave)
//   x_blue/y_blue : character position, captured at start   (master -> slave)
//   hit_in        : checker result {left,right,up,down}     (master -> slave)
//   x_ground/y_ground : tile position to the checker        (slave -> master)
//   x_blue_q/y_blue_q : latched character position          (slave -> master)
//   collide_flags/flags_valid : scan result and its strobe  (slave -> master)
//   busy/overrun  : scan in progress / sticky missed-frame  (slave -> master)
// The scheduler uses the slave modport; the environment uses master.
// -----------------------------------------------------------------------------
interface collision_scheduler_if;

  logic       frame_start;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [3:0] hit_in;
  logic [9:0] x_ground;
  logic [8:0] y_ground;
  logic [9:0] x_blue_q;
  logic [8:0] y_blue_q;
  logic [3:0] collide_flags;
  logic       flags_valid;
  logic       busy;
  logic       overrun;

  modport slave (
    input  frame_start, x_blue, y_blue, hit_in,
    output x_ground, y_ground, x_blue_q, y_blue_q,
           collide_flags, flags_valid, busy, overrun
  );

  modport master (
    output frame_start, x_blue, y_blue, hit_in,
    input  x_ground, y_ground, x_blue_q, y_blue_q,
           collide_flags, flags_valid, busy, overrun
  );

endinterface

// File: rtl/ground_tile_rom.sv
// -----------------------------------------------------------------------------
// ground_tile_rom
// Constant table of N_TILES ground tiles with a registered (1-cycle) read.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears the read register
//   addr  : tile index
//   entry : {valid, x, y} of the tile addressed on the previous cycle
// VALID_MASK bit i gives the valid bit of tile i.
// -----------------------------------------------------------------------------
module ground_tile_rom
  import collision_pkg::*;
#(
  parameter int           N_TILES    = 32,
  parameter int           ADDR_W     = 5,
  parameter logic [255:0] VALID_MASK = {256{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output tile_entry_t       entry
);

  tile_entry_t table_s [N_TILES];
  tile_entry_t entry_r;

  for (genvar gi = 0; gi < N_TILES; gi++) begin : g_table
    assign table_s[gi] = make_tile(gi, VALID_MASK[gi]);
  end

  // Synchronous table read.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_r <= '{valid: 1'b0, x: 10'd0, y: 9'd0};
    end else begin
      entry_r <= table_s[addr];
    end
  end

  assign entry = entry_r;

endmodule

// File: rtl/collision_scheduler.sv
// -----------------------------------------------------------------------------
// collision_scheduler
// Once per frame, walks the ground-tile table, presents each tile position to an
// external registered collision checker and ORs the checker's {left,right,up,down}
// answers for valid tiles into a 4-bit result.
//   clk : system clock (rising edge)
//   rst : synchronous active-high reset; aborts a scan without a result strobe
//   bus : collision_scheduler_if.slave (frame_start, x/y_blue, hit_in in;
//         x/y_ground, x/y_blue_q, collide_flags, flags_valid, busy, overrun out)
// Timing (frame_start sampled in cycle 0): indices 0..N_TILES-1 issued in cycles
// 1..N_TILES, table output one cycle later, hit_in one cycle after that, two
// DRAIN cycles, then DONE with flags_valid in cycle N_TILES+3.
// Optional macro SCAN_EARLY_EXIT_EN: stop issuing tiles once every flag is set.
// -----------------------------------------------------------------------------
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int           N_TILES         = 32,
  parameter int           ADDR_W          = 5,
  parameter logic [255:0] TILE_VALID_MASK = {256{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  collision_scheduler_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TILES - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  scan_state_e       state_r;
  scan_state_e       state_next_s;
  logic [ADDR_W-1:0] idx_r;
  logic              drain_cnt_r;
  logic              tag1_r;
  logic              tag2_r;
  logic              valid2_r;
  logic [3:0]        acc_r;
  logic [3:0]        acc_next_s;
  logic [3:0]        collide_flags_r;
  logic              flags_valid_r;
  logic              busy_r;
  logic              overrun_r;
  logic [9:0]        x_blue_q_r;
  logic [8:0]        y_blue_q_r;
  logic [9:0]        x_ground_s;
  logic [8:0]        y_ground_s;
  tile_entry_t       rom_entry_s;

  ground_tile_rom #(
    .N_TILES    (N_TILES),
    .ADDR_W     (ADDR_W),
    .VALID_MASK (TILE_VALID_MASK)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .addr  (idx_r),
    .entry (rom_entry_s)
  );

  // Accumulator input: hit_in counts only for an issued tile whose entry is valid.
  always_comb begin
    acc_next_s = acc_r;
    if (tag2_r && valid2_r) begin
      acc_next_s = acc_r | bus.hit_in;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_next_s = ST_SCAN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = ST_DRAIN;
`ifdef SCAN_EARLY_EXIT_EN
        end else if (acc_next_s == 4'b1111) begin
          // Every flag is already set; later tiles cannot change the result.
          state_next_s = ST_DRAIN;
`endif
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        // Second DRAIN cycle is the one in which the last tile's hit_in arrives.
        if (drain_cnt_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, pipeline, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      idx_r           <= '0;
      drain_cnt_r     <= 1'b0;
      tag1_r          <= 1'b0;
      tag2_r          <= 1'b0;
      valid2_r        <= 1'b0;
      acc_r           <= 4'b0000;
      collide_flags_r <= 4'b0000;
      flags_valid_r   <= 1'b0;
      busy_r          <= 1'b0;
      overrun_r       <= 1'b0;
      x_blue_q_r      <= 10'd0;
      y_blue_q_r      <= 9'd0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s != ST_IDLE);
      // Tag follows the index: stage 1 aligns with the table output, stage 2 with hit_in.
      tag1_r   <= (state_r == ST_SCAN);
      tag2_r   <= tag1_r;
      valid2_r <= rom_entry_s.valid;

      if (state_r == ST_IDLE && bus.frame_start) begin
        x_blue_q_r <= bus.x_blue;
        y_blue_q_r <= bus.y_blue;
        acc_r      <= 4'b0000;
        idx_r      <= '0;
      end else begin
        acc_r <= acc_next_s;
        // Index only advances while staying in SCAN, so it parks at its last value.
        if (state_r == ST_SCAN && state_next_s == ST_SCAN) begin
          idx_r <= idx_r + IDX_ONE;
        end else begin
          idx_r <= idx_r;
        end
      end

      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= ~drain_cnt_r;
      end else begin
        drain_cnt_r <= 1'b0;
      end

      // Load on entry to DONE so the result and its strobe are visible during DONE.
      if (state_next_s == ST_DONE) begin
        collide_flags_r <= acc_next_s;
        flags_valid_r   <= 1'b1;
      end else begin
        flags_valid_r   <= 1'b0;
      end

      if (bus.frame_start && state_r != ST_IDLE) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Present the table entry only for issued tiles; otherwise park off-screen.
  always_comb begin
    x_ground_s = PARK_X;
    y_ground_s = PARK_Y;
    if (tag1_r) begin
      x_ground_s = rom_entry_s.x;
      y_ground_s = rom_entry_s.y;
    end else begin
      x_ground_s = PARK_X;
      y_ground_s = PARK_Y;
    end
  end

  assign bus.x_ground      = x_ground_s;
  assign bus.y_ground      = y_ground_s;
  assign bus.x_blue_q      = x_blue_q_r;
  assign bus.y_blue_q      = y_blue_q_r;
  assign bus.collide_flags = collide_flags_r;
  assign bus.flags_valid   = flags_valid_r;
  assign bus.busy          = busy_r;
  assign bus.overrun       = overrun_r;

endmodule

// File: tb/tb_collision_scheduler.sv
// -----------------------------------------------------------------------------
// tb_collision_scheduler
// Drives collision_scheduler (4 tiles, tile 1 invalid) with directed and random
// scans. A registered checker model answers hit_in from a per-tile table looked
// up by tile coordinates; expected results are the OR of the valid tiles' hits.
// -----------------------------------------------------------------------------
module tb_collision_scheduler;

  localparam int         NT    = 4;
  localparam logic [3:0] VALID = 4'b1101;

  logic clk;
  logic rst;
  collision_scheduler_if bus ();

  collision_scheduler #(
    .N_TILES         (NT),
    .ADDR_W          (2),
    .TILE_VALID_MASK ({{252{1'b1}}, VALID})
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks;
  int         n_fail;
  logic [3:0] hit_tab [NT];
  logic [3:0] last_flags;
  logic       ovr_sticky;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered collision checker model: maps presented coordinates back to a tile.
  always @(posedge clk) begin
    int tidx;
    if (bus.x_ground == 10'h3FF || bus.y_ground > 9'd456) begin
      bus.hit_in <= 4'b0000;
    end else begin
      tidx = int'(bus.x_ground) / 25 + 25 * ((456 - int'(bus.y_ground)) / 24);
      bus.hit_in <= (tidx < NT) ? hit_tab[tidx] : 4'b0000;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One frame: frame_start in cycle 0, optional extra frame_start (overrun) or rst.
  task automatic run_scan(input logic [9:0] xb, input logic [8:0] yb,
                          input int ovr_cycle, input int rst_cycle);
    logic [3:0] exp_flags;
    int         fv_cycle;
    int         fv_count;
    exp_flags = 4'b0000;
    for (int i = 0; i < NT; i++) begin
      if (VALID[i]) exp_flags = exp_flags | hit_tab[i];
    end
    fv_cycle = -1;
    fv_count = 0;
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.x_blue      = xb;
    bus.y_blue      = yb;
    for (int c = 1; c <= NT + 6; c++) begin
      @(negedge clk);
      bus.frame_start = (c == ovr_cycle);
      rst             = (c == rst_cycle);
      bus.x_blue      = 10'($urandom_range(0, 1023));
      bus.y_blue      = 9'($urandom_range(0, 511));
      if (rst_cycle > 0 && c > rst_cycle) begin
        last_flags = 4'b0000;
        ovr_sticky = 1'b0;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_fv", 32'(bus.flags_valid), 32'd0);
        check_eq("rst_flags", 32'(bus.collide_flags), 32'd0);
        check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
        check_eq("rst_xground", 32'(bus.x_ground), 32'h3FF);
        check_eq("rst_xq", 32'(bus.x_blue_q), 32'd0);
      end else begin
        if (ovr_cycle > 0 && c == ovr_cycle + 1) ovr_sticky = 1'b1;
        check_eq("overrun", 32'(bus.overrun), 32'(ovr_sticky));
        check_eq("x_blue_q", 32'(bus.x_blue_q), 32'(xb));
        check_eq("y_blue_q", 32'(bus.y_blue_q), 32'(yb));
        if (bus.flags_valid) begin
          fv_count++;
          if (fv_cycle < 0) fv_cycle = c;
          check_eq("flags", 32'(bus.collide_flags), 32'(exp_flags));
          last_flags = exp_flags;
        end else begin
          check_eq("flags_hold", 32'(bus.collide_flags), 32'(last_flags));
        end
`ifdef SCAN_EARLY_EXIT_EN
        if (fv_cycle > 0 && c > fv_cycle) check_eq("busy_after", 32'(bus.busy), 32'd0);
`else
        check_eq("busy", 32'(bus.busy), 32'(c <= NT + 3));
        check_eq("x_ground", 32'(bus.x_ground),
                 (c >= 2 && c <= NT + 1) ? 32'((c - 2) * 25) : 32'h3FF);
        check_eq("y_ground", 32'(bus.y_ground),
                 (c >= 2 && c <= NT + 1) ? 32'd456 : 32'h1FF);
`endif
      end
    end
    bus.frame_start = 1'b0;
    rst             = 1'b0;
    if (rst_cycle > 0) begin
      check_eq("fv_count_abort", 32'(fv_count), 32'd0);
    end else begin
      check_eq("fv_count", 32'(fv_count), 32'd1);
`ifdef SCAN_EARLY_EXIT_EN
      check_eq("latency_bound", 32'(fv_cycle >= 1 && fv_cycle <= NT + 3), 32'd1);
`else
      check_eq("latency", 32'(fv_cycle), 32'(NT + 3));
`endif
    end
  endtask

  // Safety net in case the design wedges the simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr_c;
    int rst_c;
    n_checks        = 0;
    n_fail          = 0;
    last_flags      = 4'b0000;
    ovr_sticky      = 1'b0;
    rst             = 1'b1;
    bus.frame_start = 1'b1;   // must be ignored while rst is high
    bus.x_blue      = 10'd5;
    bus.y_blue      = 9'd7;
    for (int i = 0; i < NT; i++) hit_tab[i] = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    check_eq("reset_fv", 32'(bus.flags_valid), 32'd0);
    check_eq("reset_flags", 32'(bus.collide_flags), 32'd0);
    check_eq("reset_overrun", 32'(bus.overrun), 32'd0);
    check_eq("reset_xground", 32'(bus.x_ground), 32'h3FF);
    check_eq("reset_yground", 32'(bus.y_ground), 32'h1FF);
    check_eq("reset_xq", 32'(bus.x_blue_q), 32'd0);
    check_eq("reset_yq", 32'(bus.y_blue_q), 32'd0);
    bus.frame_start = 1'b0;
    rst             = 1'b0;
    @(negedge clk);

    // Tile 2 reports down, invalid tile 1 reports left: only down survives.
    hit_tab[0] = 4'b0000; hit_tab[1] = 4'b1000; hit_tab[2] = 4'b0001; hit_tab[3] = 4'b0000;
    run_scan(10'd100, 9'd200, 0, 0);
    // Second frame_start at cycle 3 is dropped and flagged.
    run_scan(10'd321, 9'd111, 3, 0);
    // Reset at cycle 4 aborts the scan and clears overrun; the next scan completes.
    hit_tab[0] = 4'b0110;
    run_scan(10'd17, 9'd300, 0, 4);
    run_scan(10'd900, 9'd450, 0, 0);
    // frame_start coinciding with DONE is an overrun too.
    run_scan(10'd1, 9'd2, NT + 3, 0);
`ifdef SCAN_EARLY_EXIT_EN
    hit_tab[0] = 4'b0011; hit_tab[1] = 4'b0000; hit_tab[2] = 4'b1100; hit_tab[3] = 4'b0000;
    run_scan(10'd55, 9'd66, 0, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NT; i++) begin
        hit_tab[i] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      end
      rst_c = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, NT + 2)) : 0;
      ovr_c = (rst_c == 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, NT + 3)) : 0;
      run_scan(10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)), ovr_c, rst_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
